load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit between the femtoRV32 core's execute stage and the word-addressed data memory (64 × 32-bit, asynchronous read, word-only synchronous write). It converts RV32I byte, halfword and word loads and stores into word accesses. Loads are extracted, then sign- or zero-extended. Sub-word stores are done as read-modify-write because the memory has no byte enables. The core stalls on `busy` and takes the result on the `done` pulse.

## Interface
Parameters:
- `ADDR_W`, 6 — memory word-address width; `mem_addr = addr[ADDR_W+1:2]`.

Ports (clock and reset first):
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `req` in 1 — access request; sampled only in IDLE.
- `we` in 1 — 1 = store, 0 = load.
- `funct3` in 3 — RV32I width/sign code.
- `addr` in 32 — byte address.
- `wdata` in 32 — store data; low byte/half used for SB/SH.
- `rdata` out 32 — registered load result; held until the next load completes.
- `busy` out 1 — high whenever state ≠ IDLE.
- `done` out 1 — one-cycle completion pulse.
- `err` out 1 — valid with `done`; access rejected.
- `mem_read` out 1 — to memory read strobe.
- `mem_write` out 1 — to memory write strobe.
- `mem_addr` out ADDR_W — memory word index.
- `mem_wdata` out 32 — memory write data.
- `mem_rdata` in 32 — memory read data, combinational from `mem_addr`.

## Operation
- Funct3 codes for loads:
  - 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Funct3 codes for stores: 000 SB, 001 SH, 010 SW.
- Any other code, including store 100/101, sets `err=1` with no memory access.
- Byte order is little-endian. Byte offset `k = addr[1:0]`:
  - Byte lane is bits [8k+7:8k].
  - Halfword lane is bits [8k+15:8k], with k ∈ {0,2}.
- Request latch: on `req` in IDLE, latch `addr`, `funct3`, `we` and `wdata`. Inputs are ignored while `busy`.
- FSM states: IDLE, READ, WRITE, DONE.
- Transitions from IDLE on `req`:
  - Load → READ.
  - SW → WRITE.
  - SB/SH → READ.
  - Rejected access → DONE.
- Other transitions:
  - READ (load) → DONE; `rdata` is loaded with the extracted and extended `mem_rdata`.
  - READ (SB/SH) → WRITE; `mem_rdata` is captured into the merge buffer.
  - WRITE → DONE.
  - DONE → IDLE unconditionally.
- Merge rule: the buffered word is kept, with the addressed byte or half replaced by `wdata[7:0]` or `wdata[15:0]`. SW writes `wdata` unmodified.
- Memory strobe rules:
  - `mem_read` is high only in READ.
  - `mem_write` is high only in WRITE.
  - Both strobes decode from state, so they are never high together.
- `mem_addr` is driven from the latched address in READ and WRITE, and is 0 otherwise.

## Timing
- Reset values: state IDLE; `rdata`=0, `busy`=0, `done`=0, `err`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- Latency, counting `req` accepted at cycle T and `done` high in cycle:
  - Load: T+2.
  - SW: T+2; memory updated at the edge ending T+1.
  - SB/SH: T+3.
  - Rejected access: T+1.
- `busy` is high from T+1 through the DONE cycle.
- The next request is accepted in the cycle after DONE; `req` held high at that point starts a new access.
- Reset mid-operation: `rst` in WRITE drops `mem_write` immediately and asynchronously, so the memory is not written. No `done` is produced for an aborted access. `rdata` returns to 0.
- `err`=1 never changes `rdata` or the memory.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses (LH/LHU/SH with `addr[0]`=1, LW/SW with `addr[1:0]`≠0) skip memory and go to DONE with `err=1`.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - Offending low address bits are forced to zero (aligned-down access).
  - Misalignment never sets `err`.

## Structure
- Shared package `lsu_pkg` holds:
  - Funct3 localparams (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`).
  - The state enum (`LSU_IDLE`, `LSU_READ`, `LSU_WRITE`, `LSU_DONE`).
- One sub-module, `lsu_lane`, is purely combinational and contains:
  - Load extract/extend: word, offset, funct3 → 32-bit result.
  - Store merge: old word, wdata, offset, funct3 → new word.
- The top level holds the FSM and the latches.

## Test plan
Memory is preloaded with mem[0]=5, mem[1]=0, mem[2]=1.
- LW addr 0x0 → `done` at T+2, `rdata`=0x00000005, `err`=0, one `mem_read` cycle, no `mem_write`.
- SB wdata=0x123456AB addr 0x5, then LB addr 0x5 then LBU addr 0x5:
  - Store: mem[1]=0x0000AB00, `done` at T+3.
  - Loads: `rdata`=0xFFFFFFAB, then 0x000000AB.
- SH wdata=0x8001 addr 0xA, then LH addr 0xA → mem[2]=0x80010001; `rdata`=0xFFFF8001.
- LW addr 0x6:
  - With macro: `err`=1 at T+1 and `mem_read` never asserted.
  - Without macro: `rdata`=mem[1].
- Assert `rst` during the WRITE state of SW wdata=0xDEADBEEF addr 0x0 → `mem_write` falls immediately, mem[0] stays 5, no `done`, all outputs 0.
- Pulse `req` with a different address while `busy` → request ignored; only the first access reaches memory.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes and FSM state encoding shared by the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {LSU_IDLE, LSU_READ, LSU_WRITE, LSU_DONE} lsu_state_t;
endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: little-endian byte/half lane extract+extend for loads and merge for stores
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);
  logic [1:0]  w_k;
  logic [4:0]  w_sh;
  logic [31:0] w_word_sh;
  logic [31:0] w_mask;
  // word ignores offset, half keeps only bit 1, so misaligned accesses align down
  always_comb begin
    w_k       = i_funct3[1] ? 2'b00 : i_funct3[0] ? {i_off[1], 1'b0} : i_off;
    w_sh      = {w_k, 3'b000};
    w_word_sh = i_word >> w_sh;
    o_load    = i_funct3 == F3_B  ? {{24{w_word_sh[7]}}, w_word_sh[7:0]} :
                i_funct3 == F3_H  ? {{16{w_word_sh[15]}}, w_word_sh[15:0]} :
                i_funct3 == F3_BU ? {24'd0, w_word_sh[7:0]} :
                i_funct3 == F3_HU ? {16'd0, w_word_sh[15:0]} : i_word;
    w_mask    = (i_funct3[1] ? 32'hFFFF_FFFF : i_funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << w_sh;
    o_merge   = (i_word & ~w_mask) | ((i_wdata << w_sh) & w_mask);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word loads and stores over a word-only memory.
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with err,
// otherwise misaligned addresses are silently aligned down.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  lsu_state_t        r_state;
  logic [ADDR_W+1:0] r_addr;
  logic [2:0]        r_f3;
  logic              r_we;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mem_wdata;
  logic              r_done;
  logic              r_err;
  logic              w_valid;
  logic              w_rej;
  logic [31:0]       w_load;
  logic [31:0]       w_merge;
  logic              w_unused;

  assign w_unused = ^addr[31:ADDR_W+2];

  // legality of the incoming request; misalignment only matters when trapping is built in
  always_comb begin
    w_valid = we ? (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W) :
                   (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W || funct3 == F3_BU || funct3 == F3_HU);
`ifdef LSU_MISALIGN_TRAP_EN
    w_rej = !w_valid || (funct3[1:0] == 2'b01 && addr[0]) || (funct3 == F3_W && addr[1:0] != 2'b00);
`else
    w_rej = !w_valid;
`endif
  end

  lsu_lane u_lane (
    .i_word  (mem_rdata),
    .i_wdata (r_wdata),
    .i_off   (r_addr[1:0]),
    .i_funct3(r_f3),
    .o_load  (w_load),
    .o_merge (w_merge)
  );

  // strobes and address decode straight from state so reset kills a write at once
  always_comb begin
    busy      = r_state != LSU_IDLE;
    mem_read  = r_state == LSU_READ;
    mem_write = r_state == LSU_WRITE;
    mem_addr  = (mem_read || mem_write) ? r_addr[ADDR_W+1:2] : '0;
    rdata     = r_rdata;
    done      = r_done;
    err       = r_err;
    mem_wdata = r_mem_wdata;
  end

  // request latch, access sequencing and registered results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= LSU_IDLE;
      r_addr      <= '0;
      r_f3        <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_mem_wdata <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        LSU_IDLE: if (req) begin
          r_addr  <= addr[ADDR_W+1:0];
          r_f3    <= funct3;
          r_we    <= we;
          r_wdata <= wdata;
          if (w_rej) begin
            r_state <= LSU_DONE;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else if (we && funct3 == F3_W) begin
            r_state     <= LSU_WRITE;
            r_mem_wdata <= wdata;
          end else begin
            r_state <= LSU_READ;
          end
        end
        LSU_READ: if (r_we) begin
          r_mem_wdata <= w_merge;
          r_state     <= LSU_WRITE;
        end else begin
          r_rdata <= w_load;
          r_state <= LSU_DONE;
          r_done  <= 1'b1;
        end
        LSU_WRITE: begin
          r_state <= LSU_DONE;
          r_done  <= 1'b1;
        end
        default: begin
          r_state <= LSU_IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit with a 64-word memory model
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem [64];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          passed = 0;
  int          total = 0;

  typedef struct {
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;
  exp_t sb[$];

  load_store_unit #(.ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .err(err), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  always @(negedge clk) begin
    rd_cnt += int'(mem_read);
    wr_cnt += int'(mem_write);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic access(input string tag, input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] er, input logic ee,
                        input int lat, input int nrd, input int nwr, input bit pulse);
    exp_t e;
    int n;
    sb.push_back('{er, ee, lat, nrd, nwr});
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d; rd_cnt = 0; wr_cnt = 0;
    @(posedge clk); #1;
    if (pulse) begin
      addr = a + 32'd4;
      wdata = ~d;
    end else req = 1'b0;
    n = 1;
    @(negedge clk);
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
      req = 1'b0;
    end
    req = 1'b0;
    e = sb.pop_front();
    chk({tag, " latency"}, n, e.lat);
    chk({tag, " err"}, {31'd0, err}, {31'd0, e.er});
    chk({tag, " rdata"}, rdata, e.rd);
    chk({tag, " mem_read cycles"}, rd_cnt, e.nrd);
    chk({tag, " mem_write cycles"}, wr_cnt, e.nwr);
    @(negedge clk);
    chk({tag, " done pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    mem[0] = 32'd5;
    mem[2] = 32'd1;
    #12;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("reset strobes", {30'd0, mem_read, mem_write}, 32'd0);
    chk("reset mem_addr", {26'd0, mem_addr}, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    @(negedge clk); rst = 1'b0;
    access("LW 0x0", 1'b0, 3'b010, 32'h0, 32'h0, 32'h0000_0005, 1'b0, 2, 1, 0, 1'b0);
    access("SB 0x5", 1'b1, 3'b000, 32'h5, 32'h1234_56AB, 32'h0000_0005, 1'b0, 3, 1, 1, 1'b0);
    chk("SB mem[1]", mem[1], 32'h0000_AB00);
    access("LB 0x5", 1'b0, 3'b000, 32'h5, 32'h0, 32'hFFFF_FFAB, 1'b0, 2, 1, 0, 1'b0);
    access("LBU 0x5", 1'b0, 3'b100, 32'h5, 32'h0, 32'h0000_00AB, 1'b0, 2, 1, 0, 1'b0);
    access("SH 0xA", 1'b1, 3'b001, 32'hA, 32'h0000_8001, 32'h0000_00AB, 1'b0, 3, 1, 1, 1'b0);
    chk("SH mem[2]", mem[2], 32'h8001_0001);
    access("LH 0xA", 1'b0, 3'b001, 32'hA, 32'h0, 32'hFFFF_8001, 1'b0, 2, 1, 0, 1'b0);
    access("LHU 0xA", 1'b0, 3'b101, 32'hA, 32'h0, 32'h0000_8001, 1'b0, 2, 1, 0, 1'b0);
    access("LB 0x8", 1'b0, 3'b000, 32'h8, 32'h0, 32'h0000_0001, 1'b0, 2, 1, 0, 1'b0);
    access("LB 0xB", 1'b0, 3'b000, 32'hB, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1, 0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    access("LW 0x6", 1'b0, 3'b010, 32'h6, 32'h0, 32'hFFFF_FF80, 1'b1, 1, 0, 0, 1'b0);
    access("LHU 0xB", 1'b0, 3'b101, 32'hB, 32'h0, 32'hFFFF_FF80, 1'b1, 1, 0, 0, 1'b0);
    access("SW 0x2", 1'b1, 3'b010, 32'h2, 32'h5555_5555, 32'hFFFF_FF80, 1'b1, 1, 0, 0, 1'b0);
    chk("misaligned SW mem[0]", mem[0], 32'd5);
`else
    access("LW 0x6", 1'b0, 3'b010, 32'h6, 32'h0, 32'h0000_AB00, 1'b0, 2, 1, 0, 1'b0);
    access("LHU 0xB", 1'b0, 3'b101, 32'hB, 32'h0, 32'h0000_8001, 1'b0, 2, 1, 0, 1'b0);
`endif
    access("load f3=011", 1'b0, 3'b011, 32'h0, 32'h0, rdata, 1'b1, 1, 0, 0, 1'b0);
    access("store f3=100", 1'b1, 3'b100, 32'h0, 32'h7777_7777, rdata, 1'b1, 1, 0, 0, 1'b0);
    chk("rejected store mem[0]", mem[0], 32'd5);
    access("SW 0xC busy req", 1'b1, 3'b010, 32'hC, 32'hCAFE_F00D, rdata, 1'b0, 2, 0, 1, 1'b1);
    chk("SW mem[3]", mem[3], 32'hCAFE_F00D);
    chk("ignored req mem[4]", mem[4], 32'd0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h0; wdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    req = 1'b0;
    chk("abort mem_write before rst", {31'd0, mem_write}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort mem_write", {31'd0, mem_write}, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort rdata", rdata, 32'd0);
    chk("abort mem_wdata", mem_wdata, 32'd0);
    chk("abort mem_addr", {26'd0, mem_addr}, 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort no done", {31'd0, done}, 32'd0);
    end
    chk("abort mem[0]", mem[0], 32'd5);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
